// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg: valid/ready pipeline register with a two-entry skid buffer and synchronous flush.
// Optional stall counter output enabled by defining PIPE_STAGE_STALL_CNT_EN.
module pipe_stage_skid_reg #(
    parameter int DATA_W = 101,
    parameter int CTRL_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);
    logic              main_v_q, main_v_d, skid_v_q, skid_v_d, in_ready_q, in_ready_d;
    logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic              acc, drn;

    assign acc       = in_valid & in_ready_q;
    assign drn       = main_v_q & out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = main_v_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_v_q ? main_ctrl_q : '0;

    always_comb begin
        main_v_d    = main_v_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_v_d    = skid_v_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (flush) begin
            main_v_d    = 1'b0;
            main_data_d = '0;
            main_ctrl_d = '0;
            skid_v_d    = 1'b0;
            skid_data_d = '0;
            skid_ctrl_d = '0;
        end else if (skid_v_q) begin
            // in_ready is low here, so only a drain can move anything
            if (drn) begin
                main_v_d    = 1'b1;
                main_data_d = skid_data_q;
                main_ctrl_d = skid_ctrl_q;
                skid_v_d    = 1'b0;
            end
        end else if (acc && (!main_v_q || drn)) begin
            main_v_d    = 1'b1;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
        end else if (acc) begin
            skid_v_d    = 1'b1;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
        end else if (drn) begin
            main_v_d = 1'b0;
        end
        in_ready_d = !skid_v_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_v_q    <= 1'b0;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_v_q    <= 1'b0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            main_v_q    <= main_v_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_v_q    <= skid_v_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            in_ready_q  <= in_ready_d;
        end
    end

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [31:0] stall_cnt_q;
    assign stall_cnt = stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_cnt_q <= '0;
        else if (main_v_q && !out_ready && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
`endif
endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb_pipe_stage_skid_reg: scoreboard bench for pipe_stage_skid_reg; stimulus pushes expected entries, a monitor pops on each drain.
module tb_pipe_stage_skid_reg;
    localparam int DW = 101;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, out_ready;
    logic          in_ready, out_valid;
    logic [DW-1:0] in_data, out_data;
    logic [CW-1:0] in_ctrl, out_ctrl;
`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    int n_chk = 0;
    int n_fail = 0;
    logic [DW+CW-1:0] exp_q[$];

    pipe_stage_skid_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl)
`ifdef PIPE_STAGE_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int d, input int c);
        in_valid = v;
        in_data  = DW'(d);
        in_ctrl  = CW'(c);
    endtask

    task automatic expect_entry(input int d, input int c);
        exp_q.push_back({DW'(d), CW'(c)});
    endtask

    // Outputs are stable at the falling edge; a drain here completes at the next rising edge
    always @(negedge clk) begin
        if (!reset) begin
            if (!out_valid) chk("bubble_ctrl", 128'(out_ctrl), 128'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 128'({out_data, out_ctrl}), 128'd0);
                    if ({out_data, out_ctrl} == '0) begin
                        n_fail++;
                        $display("FAIL unexpected_output: got zero entry expected none");
                    end
                end else begin
                    chk("sb_entry", 128'({out_data, out_ctrl}), 128'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(0, 0, 0);
        step(); step();
        chk("rst_valid", 128'(out_valid), 128'd0);
        chk("rst_data", 128'(out_data), 128'd0);
        chk("rst_ctrl", 128'(out_ctrl), 128'd0);
        chk("rst_ready", 128'(in_ready), 128'd1);
        reset = 1'b0;
        step();

        // pass-through at full rate
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1, i, i);
            expect_entry(i, i);
            chk("pt_ready", 128'(in_ready), 128'd1);
            step();
            chk("pt_data", 128'(out_data), 128'(i));
        end
        drive(0, 0, 0);
        step(); step();
        chk("pt_empty", 128'(exp_q.size()), 128'd0);

        // back-pressure fills both entries
        out_ready = 1'b0;
        drive(1, 'hA, 1); expect_entry('hA, 1); step();
        drive(1, 'hB, 2); expect_entry('hB, 2); step();
        drive(0, 0, 0);
        chk("bp_ready", 128'(in_ready), 128'd0);
        chk("bp_valid", 128'(out_valid), 128'd1);
        chk("bp_data", 128'(out_data), 128'hA);
        out_ready = 1'b1;
        step();
        chk("bp_second", 128'(out_data), 128'hB);
        chk("bp_ready_back", 128'(in_ready), 128'd1);
        step();
        chk("bp_ready_end", 128'(in_ready), 128'd1);
        chk("bp_valid_end", 128'(out_valid), 128'd0);
        chk("bp_drained", 128'(exp_q.size()), 128'd0);

        // bubble keeps control bits at zero
        drive(0, 'h55, 'h3F);
        step();
        chk("bub_ctrl", 128'(out_ctrl), 128'd0);
        chk("bub_valid", 128'(out_valid), 128'd0);
        drive(1, 'h55, 'h3F); expect_entry('h55, 'h3F);
        step();
        drive(0, 0, 0);
        chk("bub_ctrl_live", 128'(out_ctrl), 128'h3F);
        step();
        chk("bub_drained", 128'(exp_q.size()), 128'd0);

        // flush a full stage while offering C; none of A2, B2, C may appear
        out_ready = 1'b0;
        drive(1, 'hA2, 3); step();
        drive(1, 'hB2, 4); step();
        chk("fl_full", 128'(in_ready), 128'd0);
        flush = 1'b1;
        drive(1, 'hC, 5);
        step();
        flush = 1'b0;
        drive(0, 0, 0);
        chk("fl_valid", 128'(out_valid), 128'd0);
        chk("fl_ctrl", 128'(out_ctrl), 128'd0);
        chk("fl_data", 128'(out_data), 128'd0);
        chk("fl_ready", 128'(in_ready), 128'd1);
        out_ready = 1'b1;
        step(); step(); step();
        chk("fl_still_empty", 128'(out_valid), 128'd0);

        // asynchronous reset mid-cycle with both entries full
        out_ready = 1'b0;
        drive(1, 'hD1, 6); step();
        drive(1, 'hD2, 7); step();
        drive(0, 0, 0);
        chk("ar_full", 128'(in_ready), 128'd0);
        #2 reset = 1'b1;
        #1;
        chk("ar_valid", 128'(out_valid), 128'd0);
        chk("ar_ctrl", 128'(out_ctrl), 128'd0);
        chk("ar_data", 128'(out_data), 128'd0);
        chk("ar_ready", 128'(in_ready), 128'd1);
        step();
        reset = 1'b0;
        step();

`ifdef PIPE_STAGE_STALL_CNT_EN
        chk("sc_reset", 128'(stall_cnt), 128'd0);
        drive(1, 'hE, 9); expect_entry('hE, 9);
        step();
        drive(0, 0, 0);
        for (int i = 0; i < 5; i++) step();
        chk("sc_five", 128'(stall_cnt), 128'd5);
        out_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("sc_flush_keep", 128'(stall_cnt), 128'd5);
        step();
        #2 reset = 1'b1;
        #1;
        chk("sc_cleared", 128'(stall_cnt), 128'd0);
        step();
        reset = 1'b0;
        step();
`endif

        chk("sb_final_empty", 128'(exp_q.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
Parametrised pipeline stage register for the processor datapath.
- Generalises the fixed inter-stage registers: configurable data and control widths.
- Adds a valid/ready handshake, a two-entry skid buffer for back-pressure, and synchronous flush for bubble insertion.
- Instantiated between any two pipeline stages (ID/EX, EX/MEM, MEM/WB); control bits are forced to zero whenever the stage holds a bubble.

Parameters:
DATA_W, 101, width of the packed datapath payload (e.g. ALU results, rt value, zero flag, destination register address)
CTRL_W, 6, width of the packed control bits (e.g. jump, branch, MemRead, MemtoReg, MemWrite, RegWrite)

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous flush; empties the stage
in_valid  input  1  upstream has a valid entry
in_ready  output  1  stage can accept an entry; registered
in_data  input  DATA_W  upstream payload
in_ctrl  input  CTRL_W  upstream control bits
out_valid  output  1  stage holds a valid entry
out_ready  input  1  downstream accepts the entry this cycle
out_data  output  DATA_W  payload of the main entry
out_ctrl  output  CTRL_W  control bits of the main entry; zero when out_valid=0

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Storage: main entry (main_v, main_data, main_ctrl) and skid entry (skid_v, skid_data, skid_ctrl).
- Outputs: out_valid=main_v; out_data=main_data; out_ctrl=main_v ? main_ctrl : 0. in_ready=!skid_v, always driven from a register.
- Reset values: main_v=skid_v=0; all data/ctrl regs=0; so out_valid=0, out_data=0, out_ctrl=0, in_ready=1.
  - Reset mid-stream discards both entries immediately, with no clock edge needed.
- Handshake: acc = in_valid & in_ready; drn = out_valid & out_ready. Upstream must hold in_* stable while in_valid=1 and in_ready=0.
- Next-state, no flush:
  - skid_v=1, drn=1: main<=skid, skid_v<=0. No accept is possible because in_ready=0.
  - skid_v=1, drn=0: hold everything.
  - skid_v=0, acc=1, (main_v=0 or drn=1): main<=in, main_v<=1.
  - skid_v=0, acc=1, main_v=1, drn=0: skid<=in, skid_v<=1; in_ready drops next cycle.
  - skid_v=0, acc=0, drn=1: main_v<=0.
  - Otherwise: hold.
- Latency and throughput: 1 cycle input to output when empty; 1 entry/cycle sustained when out_ready=1. Entry order is strictly preserved (FIFO).
- Full: both entries valid means in_ready=0. Empty: main_v=0 means out_valid=0. The skid entry is never valid while main is invalid.
- Flush: highest priority. Next cycle main_v=skid_v=0, ctrl regs cleared to 0, in_ready=1.
  - Data regs are cleared to 0 as well.
  - An input offered in the flush cycle is dropped, even if in_ready=1.
  - A drain in the flush cycle completes normally: downstream consumed that entry.
- Flush and reset: flush has no effect while reset is high.

Optional Feature:
Macro: PIPE_STAGE_STALL_CNT_EN.
- Defined: adds output port stall_cnt, 32 bits.
  - Increments each cycle with out_valid=1 and out_ready=0.
  - Saturates at 32'hFFFFFFFF.
  - Cleared only by reset; flush does not clear it.
- Undefined: the port and counter logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset: assert reset asynchronously mid-cycle with both entries full -> out_valid=0, out_ctrl=0, out_data=0, in_ready=1 immediately, with no clock edge needed.
- Pass-through: out_ready=1, in_valid=1 with in_data=1..8 on consecutive cycles -> out_data=1..8 one cycle later, no gaps, in_ready stays 1.
- Back-pressure: out_ready=0, send A then B -> after 2 edges in_ready=0, out_data=A. Raise out_ready for 2 cycles -> A then B delivered, then in_ready=1, out_valid=0.
- Bubble: in_ctrl=6'b111111 with in_valid=0 -> out_ctrl=0, out_valid=0. Then in_valid=1 with the same ctrl -> out_ctrl=6'b111111 next cycle.
- Flush: stage full (A, B), flush=1 and in_valid=1 with C -> next cycle out_valid=0, out_ctrl=0, in_ready=1, and C never appears at the output.
- Stall counter (macro defined): hold out_valid=1 with out_ready=0 for 5 cycles -> stall_cnt=5. Flush -> stall_cnt still 5. Reset -> stall_cnt=0.
